bus_arbiter: RTL and testbench

//  Shares the single 16-bit processor bus/BIU between the fetch unit (fcu) and the execution unit (eu).

---
 rtl/cpu_bus_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 28 ++
 rtl/bus_arbiter.sv | 138 +++++++++++++
 tb/tb_bus_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared bus codes, arbiter state encoding and requester ids
package cpu_bus_pkg;

   // BIU transfer codes carried on sel_biu
   localparam logic [1:0] SEL_RD    = 2'b00;
   localparam logic [1:0] SEL_WR    = 2'b01;
   localparam logic [1:0] SEL_FETCH = 2'b10;
   localparam logic [1:0] SEL_RSVD  = 2'b11;

   // Arbiter FSM encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_ABORT = 3'd4;

   // Requester ids
   localparam logic ID_FCU = 1'b0;
   localparam logic ID_EU  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way picker between fcu and eu
module rr_arb2
   import cpu_bus_pkg::*;
#(
   parameter int FCU_PRIO = 0
) (
   input  logic req_fcu,
   input  logic req_eu,
   input  logic last_gnt,
   output logic gnt_id,
   output logic valid
);

   // Single request wins outright; on contention either fcu wins or the one not served last
   always_comb begin
      valid  = req_fcu | req_eu;
      gnt_id = ID_FCU;
      if (req_fcu && req_eu) begin
         if (FCU_PRIO != 0)
            gnt_id = ID_FCU;
         else
            gnt_id = (last_gnt == ID_FCU) ? ID_EU : ID_FCU;
      end else if (req_eu) begin
         gnt_id = ID_EU;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares the BIU between fcu and eu with timeout abort
module bus_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int TIMEOUT  = 16,
   parameter int FCU_PRIO = 0,
   parameter int AW       = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_fcu,
   input  logic [1:0]    sel_fcu,
   input  logic [AW-1:0] addr_fcu,
   input  logic          req_eu,
   input  logic [1:0]    sel_eu,
   input  logic [AW-1:0] addr_eu,
   input  logic          ready_bus,
   output logic          cs_biu,
   output logic [1:0]    sel_biu,
   output logic [AW-1:0] biu_addr,
   output logic          gnt_fcu,
   output logic          gnt_eu,
   output logic          done_fcu,
   output logic          done_eu,
   output logic          err,
   output logic          timeout_err,
   output logic          busy
);

   localparam int            CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic          last_gnt;
   logic          pick_id;
   logic          pick_valid;

   rr_arb2 #(
      .FCU_PRIO (FCU_PRIO)
   ) u_pick (
      .req_fcu  (req_fcu),
      .req_eu   (req_eu),
      .last_gnt (last_gnt),
      .gnt_id   (pick_id),
      .valid    (pick_valid)
   );

   assign busy = (state != ST_IDLE);

   // Transaction sequencing and the WAIT-cycle timeout counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid)
                  state <= ST_ISSUE;
            end
            ST_ISSUE: begin
               state <= ST_WAIT;
               cnt   <= '0;
            end
            ST_WAIT: begin
               if (ready_bus) begin
                  state <= ST_DONE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= ST_ABORT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Grant ownership and latched transfer code/address, frozen from grant to exit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_fcu  <= 1'b0;
         gnt_eu   <= 1'b0;
         last_gnt <= ID_EU;
         sel_biu  <= '0;
         biu_addr <= '0;
      end else begin
         if (state == ST_IDLE && pick_valid) begin
            gnt_fcu  <= (pick_id == ID_FCU);
            gnt_eu   <= (pick_id == ID_EU);
            last_gnt <= pick_id;
            sel_biu  <= (pick_id == ID_FCU) ? sel_fcu : sel_eu;
            biu_addr <= (pick_id == ID_FCU) ? addr_fcu : addr_eu;
         end else if (state == ST_DONE || state == ST_ABORT) begin
            gnt_fcu <= 1'b0;
            gnt_eu  <= 1'b0;
         end
      end
   end

   // Chip select, one-cycle done/err pulses and the sticky timeout flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cs_biu      <= 1'b0;
         done_fcu    <= 1'b0;
         done_eu     <= 1'b0;
         err         <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         done_fcu <= 1'b0;
         done_eu  <= 1'b0;
         err      <= 1'b0;
         case (state)
            ST_IDLE: cs_biu <= pick_valid;
            ST_WAIT: begin
               if (ready_bus || cnt == CNT_LAST) begin
                  cs_biu   <= 1'b0;
                  done_fcu <= gnt_fcu;
                  done_eu  <= gnt_eu;
                  if (!ready_bus) begin
                     err         <= 1'b1;
                     timeout_err <= 1'b1;
                  end
               end
            end
            ST_ISSUE: cs_biu <= 1'b1;
            default:  cs_biu <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
`timescale 1ns/1ps
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_fcu = 1'b0;
   logic [1:0]  sel_fcu = 2'b00;
   logic [15:0] addr_fcu = 16'h0000;
   logic        req_eu = 1'b0;
   logic [1:0]  sel_eu = 2'b00;
   logic [15:0] addr_eu = 16'h0000;
   logic        ready_bus = 1'b0;

   logic        cs_biu, gnt_fcu, gnt_eu, done_fcu, done_eu, err, timeout_err, busy;
   logic [1:0]  sel_biu;
   logic [15:0] biu_addr;

   logic        p_cs, p_gf, p_ge, p_df, p_de, p_err, p_to, p_busy;
   logic [1:0]  p_sel;
   logic [15:0] p_addr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.TIMEOUT(16), .FCU_PRIO(0), .AW(16)) dut (
      .clk(clk), .reset(reset),
      .req_fcu(req_fcu), .sel_fcu(sel_fcu), .addr_fcu(addr_fcu),
      .req_eu(req_eu), .sel_eu(sel_eu), .addr_eu(addr_eu),
      .ready_bus(ready_bus),
      .cs_biu(cs_biu), .sel_biu(sel_biu), .biu_addr(biu_addr),
      .gnt_fcu(gnt_fcu), .gnt_eu(gnt_eu), .done_fcu(done_fcu), .done_eu(done_eu),
      .err(err), .timeout_err(timeout_err), .busy(busy)
   );

   bus_arbiter #(.TIMEOUT(16), .FCU_PRIO(1), .AW(16)) dut_p (
      .clk(clk), .reset(reset),
      .req_fcu(req_fcu), .sel_fcu(sel_fcu), .addr_fcu(addr_fcu),
      .req_eu(req_eu), .sel_eu(sel_eu), .addr_eu(addr_eu),
      .ready_bus(ready_bus),
      .cs_biu(p_cs), .sel_biu(p_sel), .biu_addr(p_addr),
      .gnt_fcu(p_gf), .gnt_eu(p_ge), .done_fcu(p_df), .done_eu(p_de),
      .err(p_err), .timeout_err(p_to), .busy(p_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      req_fcu   = 1'b0;
      req_eu    = 1'b0;
      ready_bus = 1'b0;
      step(2);
      reset = 1'b1;
   endtask

   logic exp_rr [3];
   int   cs_cnt;
   int   done_cnt;
   int   err_cnt;
   int   done_idx;

   initial begin
      exp_rr[0] = 1'b1;
      exp_rr[1] = 1'b0;
      exp_rr[2] = 1'b1;

      // 1: reset held with both requests high
      reset    = 1'b0;
      req_fcu  = 1'b1;
      req_eu   = 1'b1;
      addr_fcu = 16'h0A0A;
      addr_eu  = 16'h0B0B;
      step(3);
      chk("rst_flags", {24'd0, cs_biu, gnt_fcu, gnt_eu, done_fcu, done_eu, err, timeout_err, busy}, 32'd0);
      chk("rst_addr_sel", {14'd0, sel_biu, biu_addr}, 32'd0);
      reset = 1'b1;
      step(1);
      chk("rst_first_gnt", {29'd0, gnt_fcu, gnt_eu, cs_biu}, 32'b101);

      // 2: fcu alone, ready on third WAIT cycle
      do_reset();
      req_fcu  = 1'b1;
      addr_fcu = 16'h0100;
      sel_fcu  = 2'b10;
      step(1);
      chk("t2_latch", {14'd0, sel_biu, biu_addr}, {14'd0, 2'b10, 16'h0100});
      chk("t2_gnt", {29'd0, gnt_fcu, gnt_eu, busy}, 32'b101);
      cs_cnt   = cs_biu;
      done_cnt = 0;
      err_cnt  = 0;
      for (int i = 1; i < 8; i++) begin
         if (i == 4) ready_bus = 1'b1;
         step(1);
         cs_cnt   += cs_biu;
         done_cnt += done_fcu;
         if (done_fcu && err) err_cnt++;
         if (done_fcu) begin
            ready_bus = 1'b0;
            req_fcu   = 1'b0;
         end
      end
      chk("t2_cs_cycles", cs_cnt, 32'd4);
      chk("t2_done_cycles", done_cnt, 32'd1);
      chk("t2_err", err_cnt, 32'd0);
      chk("t2_idle", {30'd0, busy, gnt_fcu}, 32'd0);

      // 3: contention with ready held high
      do_reset();
      req_fcu   = 1'b1;
      req_eu    = 1'b1;
      addr_fcu  = 16'h1111;
      addr_eu   = 16'h2222;
      ready_bus = 1'b1;
      for (int t = 0; t < 3; t++) begin
         step(1);
         chk("t3_rr_gnt", {30'd0, gnt_fcu, gnt_eu}, {30'd0, exp_rr[t], ~exp_rr[t]});
         chk("t3_rr_addr", {16'd0, biu_addr}, exp_rr[t] ? 32'h1111 : 32'h2222);
         chk("t3_prio_gnt", {30'd0, p_gf, p_ge}, 32'b10);
         step(2);
         chk("t3_rr_done", {30'd0, done_fcu, done_eu}, {30'd0, exp_rr[t], ~exp_rr[t]});
         step(1);
      end
      req_fcu   = 1'b0;
      req_eu    = 1'b0;
      ready_bus = 1'b0;

      // 4: eu never answered, timeout abort
      do_reset();
      req_eu  = 1'b1;
      addr_eu = 16'h0300;
      sel_eu  = 2'b00;
      step(1);
      chk("t4_gnt", {30'd0, gnt_fcu, gnt_eu}, 32'b01);
      cs_cnt   = cs_biu;
      done_idx = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1);
         if (done_eu) begin
            done_idx = i;
            break;
         end
         cs_cnt += cs_biu;
      end
      chk("t4_abort_edge", done_idx, 32'd17);
      chk("t4_cs_cycles", cs_cnt, 32'd17);
      chk("t4_abort_flags", {28'd0, err, timeout_err, cs_biu, gnt_eu}, 32'b1101);
      req_eu = 1'b0;
      step(1);
      chk("t4_after", {28'd0, done_eu, err, timeout_err, gnt_eu}, 32'b0010);
      step(2);
      chk("t4_sticky", {30'd0, timeout_err, busy}, 32'b10);

      // 5: inputs change after grant
      req_eu  = 1'b1;
      addr_eu = 16'h0200;
      sel_eu  = 2'b01;
      step(2);
      addr_eu = 16'hFFFF;
      sel_eu  = 2'b11;
      req_eu  = 1'b0;
      step(1);
      chk("t5_addr_hold", {14'd0, sel_biu, biu_addr}, {14'd0, 2'b01, 16'h0200});
      ready_bus = 1'b1;
      step(1);
      chk("t5_done", {29'd0, done_eu, err, cs_biu}, 32'b100);
      chk("t5_addr_done", {16'd0, biu_addr}, 32'h0200);
      ready_bus = 1'b0;
      step(1);
      chk("t5_pulse_end", {30'd0, done_eu, timeout_err}, 32'b01);

      // 6: reset in the middle of WAIT
      req_fcu  = 1'b1;
      addr_fcu = 16'h0400;
      sel_fcu  = 2'b00;
      step(3);
      chk("t6_in_wait", {29'd0, cs_biu, gnt_fcu, busy}, 32'b111);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_async_drop", {29'd0, cs_biu, gnt_fcu, busy}, 32'b000);
      ready_bus = 1'b1;
      step(1);
      chk("t6_no_done", {29'd0, done_fcu, done_eu, timeout_err}, 32'b000);
      ready_bus = 1'b0;
      reset     = 1'b1;
      step(1);
      chk("t6_restart", {29'd0, gnt_fcu, cs_biu, busy}, 32'b111);
      chk("t6_restart_addr", {16'd0, biu_addr}, 32'h0400);
      ready_bus = 1'b1;
      step(2);
      chk("t6_done", {30'd0, done_fcu, err}, 32'b10);
      req_fcu   = 1'b0;
      ready_bus = 1'b0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
